// File: rtl/mulreg_arb.sv
// -----------------------------------------------------------------------------
// mulreg_arb
//   Round-robin arbiter that shares one two-stage registered signed multiplier
//   between R requesters. Stage 1 registers the winning operands and tag.
//   Stage 2 registers the truncated product and drives the result channel.
//   Results leave in acceptance order. Back-pressure stalls the whole pipe,
//   so no result is ever lost or duplicated.
//
// Ports
//   clk        rising-edge clock
//   nreset     asynchronous active-low reset (drops all in-flight work)
//   req_valid  [R]      per-requester operand valid
//   req_ready  [R]      per-requester accept, one-hot or zero, combinational
//   req_a      [R*N]    packed signed operand a, requester i at [i*N +: N]
//   req_b      [R*N]    packed signed operand b, same packing
//   out_valid           result valid (stage-2 valid)
//   out_ready           downstream accepts the result
//   out_id     [IDW]    index of the requester that issued the result
//   out_prod   [M]      low M bits of the signed product a*b
//   busy                any stage valid or any request pending
// -----------------------------------------------------------------------------
module mulreg_arb #(
  parameter int N   = 8,
  parameter int M   = 16,
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IDW-1:0] out_id,
  output logic [M-1:0]   out_prod,
  output logic           busy
);

  logic [IDW-1:0]        ptr;
  logic [IDW-1:0]        ptr_next;

  logic                  s1_valid;
  logic signed [N-1:0]   s1_a;
  logic signed [N-1:0]   s1_b;
  logic [IDW-1:0]        s1_tag;

  logic                  adv1;
  logic                  adv2;
  logic                  win_found;
  logic [IDW-1:0]        win_idx;
  logic                  xfer;

  logic signed [N-1:0]   sel_a;
  logic signed [N-1:0]   sel_b;
  logic signed [M-1:0]   a_ext;
  logic signed [M-1:0]   b_ext;
  logic signed [M-1:0]   prod_m;

  // Stall chain: stage 2 moves when empty or drained, stage 1 when it can
  // hand its contents to stage 2 (or holds nothing).
  assign adv2 = !out_valid || out_ready;
  assign adv1 = !s1_valid || adv2;

  // Round-robin search starting at ptr, wrapping through R-1 back to 0.
  always_comb begin : arb_search
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < R; k++) begin
      j = int'(ptr) + k;
      if (j >= R) j = j - R;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IDW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (nreset && adv1 && win_found) req_ready[win_idx] = 1'b1;
  end

  assign xfer     = nreset && adv1 && win_found;
  assign ptr_next = (win_idx == IDW'(R-1)) ? '0 : win_idx + 1'b1;

  assign sel_a = req_a[int'(win_idx)*N +: N];
  assign sel_b = req_b[int'(win_idx)*N +: N];

  // The low M bits of a two's-complement product depend only on the low M
  // bits of the sign-extended operands, so an M x M multiply yields exactly
  // trunc_M of the full product, and sign-extends it when M >= 2N.
  assign a_ext  = M'(s1_a);
  assign b_ext  = M'(s1_b);
  assign prod_m = a_ext * b_ext;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr       <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_prod  <= '0;
    end else begin
      if (xfer) ptr <= ptr_next;
      if (adv1) s1_valid <= xfer;
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_id   <= s1_tag;
          out_prod <= prod_m;
        end
      end
    end
  end

  // Operand/tag payload is qualified by s1_valid and needs no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_a   <= sel_a;
      s1_b   <= sel_b;
      s1_tag <= win_idx;
    end
  end

  assign busy = s1_valid || out_valid || (|req_valid);

endmodule
